// File: rtl/fetcher_pkg.sv
// Shared fetch-stage constants: RV32/RVC control-flow encodings, FSM states, BHT defaults.
// Purely declarative; no timing or flow control of its own.
package fetcher_pkg;

  localparam int XLEN          = 32;
  localparam int BHT_IDX_W_DEF = 6;

  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [1:0] RVC_Q1 = 2'b01;
  localparam logic [1:0] RVC_Q2 = 2'b10;

  localparam logic [2:0] C_F3_JAL  = 3'b001;
  localparam logic [2:0] C_F3_J    = 3'b101;
  localparam logic [2:0] C_F3_BEQZ = 3'b110;
  localparam logic [2:0] C_F3_BNEZ = 3'b111;
  localparam logic [2:0] C_F3_JR   = 3'b100;

  localparam logic [1:0] BHT_INIT = 2'b01;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_WAIT = 1'b1
  } fet_state_e;

  function automatic logic [1:0] bht_sat(input logic [1:0] cnt, input logic taken);
    logic [1:0] r;
    r = cnt;
    if (taken && cnt != 2'b11) r = cnt + 2'b01;
    else if (!taken && cnt != 2'b00) r = cnt - 2'b01;
    return r;
  endfunction

endpackage

// File: rtl/fetcher_predecode.sv
// Combinational predecode of one fetched word: length, control-flow class, sign-extended offset.
// Zero latency; no flow control.
module fetcher_predecode
  import fetcher_pkg::*;
(
  input  logic [XLEN-1:0] inst,
  output logic            is_c,
  output logic            is_jal,
  output logic            is_jalr,
  output logic            is_branch,
  output logic [XLEN-1:0] imm
);

  logic [XLEN-1:0] j_imm, b_imm, cj_imm, cb_imm;
  logic [2:0]      c_f3;

  assign c_f3   = inst[15:13];
  assign j_imm  = {{12{inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};
  assign b_imm  = {{20{inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0};
  assign cj_imm = {{20{inst[12]}}, inst[12], inst[8], inst[10:9], inst[6], inst[7],
                   inst[2], inst[11], inst[5:3], 1'b0};
  assign cb_imm = {{23{inst[12]}}, inst[12], inst[6:5], inst[2], inst[11:10], inst[4:3], 1'b0};

  always_comb begin
    is_c      = (inst[1:0] != 2'b11);
    is_jal    = 1'b0;
    is_jalr   = 1'b0;
    is_branch = 1'b0;
    imm       = '0;
    if (!is_c) begin
      is_jal    = (inst[6:0] == OP_JAL);
      is_jalr   = (inst[6:0] == OP_JALR);
      is_branch = (inst[6:0] == OP_BRANCH);
      imm       = is_jal ? j_imm : b_imm;
    end else if (inst[1:0] == RVC_Q1) begin
      if (c_f3 == C_F3_J || c_f3 == C_F3_JAL) begin
        is_jal = 1'b1;
        imm    = cj_imm;
      end else if (c_f3 == C_F3_BEQZ || c_f3 == C_F3_BNEZ) begin
        is_branch = 1'b1;
        imm       = cb_imm;
      end
    end else if (inst[1:0] == RVC_Q2) begin
      // C.JR / C.JALR: rs2 must be zero and rs1 non-zero (rs1=0 is C.EBREAK or reserved)
      is_jalr = (c_f3 == C_F3_JR) && (inst[6:2] == 5'd0) && (inst[11:7] != 5'd0);
    end
  end

endmodule

// File: rtl/fetcher.sv
// Fetch stage: owns the PC, pushes icache hits to the IQ one cycle later, predicts with a 2-bit BHT.
// Holds PC on miss, iq_full or stall; parks after JALR until a flush redirects it.
module fetcher
  import fetcher_pkg::*;
#(
  parameter int              BHT_IDX_W = BHT_IDX_W_DEF,
  parameter logic [XLEN-1:0] RESET_PC  = 32'h0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            rdy,
  input  logic            flush,
  input  logic            stall,
  input  logic [XLEN-1:0] rob_redirect_pc,
  input  logic            icache_ready,
  input  logic [XLEN-1:0] icache_inst,
  output logic            fet_icache_enable,
  output logic [XLEN-1:0] fet_pc,
  input  logic            iq_full,
  output logic            fet_iq_enable,
  output logic [XLEN-1:0] fet_inst,
  output logic [XLEN-1:0] fet_inst_pc,
  output logic            fet_pred_taken,
  output logic            fet_is_c,
  input  logic            bp_update_enable,
  input  logic [XLEN-1:0] bp_update_pc,
  input  logic            bp_update_taken
);

  localparam int BHT_N = 1 << BHT_IDX_W;

  fet_state_e      state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            iq_en_q, iq_en_d;
  logic [XLEN-1:0] inst_q, inst_d;
  logic [XLEN-1:0] inst_pc_q, inst_pc_d;
  logic            taken_q, taken_d;
  logic            is_c_q, is_c_d;
  logic [1:0]      bht_q [BHT_N];

  logic                 pd_is_c, pd_is_jal, pd_is_jalr, pd_is_branch;
  logic [XLEN-1:0]      pd_imm;
  logic                 push, pred_taken;
  logic [XLEN-1:0]      target, seq_pc;
  logic [BHT_IDX_W-1:0] rd_idx, upd_idx;
  logic                 unused_bp_pc;

  fetcher_predecode u_predecode (
    .inst      (icache_inst),
    .is_c      (pd_is_c),
    .is_jal    (pd_is_jal),
    .is_jalr   (pd_is_jalr),
    .is_branch (pd_is_branch),
    .imm       (pd_imm)
  );

  assign rd_idx       = pc_q[BHT_IDX_W:1];
  assign upd_idx      = bp_update_pc[BHT_IDX_W:1];
  assign unused_bp_pc = ^{bp_update_pc[XLEN-1:BHT_IDX_W+1], bp_update_pc[0]};

  assign fet_icache_enable = (state_q == ST_RUN) && !flush && !stall;
  assign push              = fet_icache_enable && icache_ready && !iq_full;
  assign pred_taken        = pd_is_jal || (pd_is_branch && bht_q[rd_idx][1]);
  assign target            = pc_q + pd_imm;
  assign seq_pc            = pc_q + (pd_is_c ? 32'd2 : 32'd4);

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    iq_en_d   = 1'b0;
    inst_d    = inst_q;
    inst_pc_d = inst_pc_q;
    taken_d   = taken_q;
    is_c_d    = is_c_q;
    if (flush) begin
      state_d = ST_RUN;
      pc_d    = {rob_redirect_pc[XLEN-1:1], 1'b0};
    end else if (push) begin
      iq_en_d   = 1'b1;
      inst_d    = icache_inst;
      inst_pc_d = pc_q;
      taken_d   = pred_taken;
      is_c_d    = pd_is_c;
      pc_d      = pred_taken ? {target[XLEN-1:1], 1'b0} : {seq_pc[XLEN-1:1], 1'b0};
      if (pd_is_jalr) state_d = ST_WAIT;
    end
  end

  always_ff @(posedge clk) begin
    if (rdy) begin
      if (rst) begin
        state_q   <= ST_RUN;
        pc_q      <= RESET_PC;
        iq_en_q   <= 1'b0;
        inst_q    <= '0;
        inst_pc_q <= '0;
        taken_q   <= 1'b0;
        is_c_q    <= 1'b0;
      end else begin
        state_q   <= state_d;
        pc_q      <= pc_d;
        iq_en_q   <= iq_en_d;
        inst_q    <= inst_d;
        inst_pc_q <= inst_pc_d;
        taken_q   <= taken_d;
        is_c_q    <= is_c_d;
      end
    end
  end

  // Training is independent of flush/stall; same-edge prediction reads the pre-update counter.
  always_ff @(posedge clk) begin
    if (rdy) begin
      if (rst) begin
        for (int i = 0; i < BHT_N; i++) bht_q[i] <= BHT_INIT;
      end else if (bp_update_enable) begin
        bht_q[upd_idx] <= bht_sat(bht_q[upd_idx], bp_update_taken);
      end
    end
  end

  assign fet_pc         = pc_q;
  assign fet_iq_enable  = iq_en_q;
  assign fet_inst       = inst_q;
  assign fet_inst_pc    = inst_pc_q;
  assign fet_pred_taken = taken_q;
  assign fet_is_c       = is_c_q;

endmodule

// File: tb/tb_fetcher.sv
// Directed cycle-by-cycle vector table for the fetch stage; each row is one clock edge.
module tb_fetcher;

  logic        clk = 1'b0;
  logic        rst, rdy, flush, stall, icache_ready, iq_full;
  logic        bp_update_enable, bp_update_taken;
  logic [31:0] rob_redirect_pc, icache_inst, bp_update_pc;
  logic        fet_icache_enable, fet_iq_enable, fet_pred_taken, fet_is_c;
  logic [31:0] fet_pc, fet_inst, fet_inst_pc;

  int n_chk = 0;
  int n_err = 0;

  fetcher dut (
    .clk               (clk),
    .rst               (rst),
    .rdy               (rdy),
    .flush             (flush),
    .stall             (stall),
    .rob_redirect_pc   (rob_redirect_pc),
    .icache_ready      (icache_ready),
    .icache_inst       (icache_inst),
    .fet_icache_enable (fet_icache_enable),
    .fet_pc            (fet_pc),
    .iq_full           (iq_full),
    .fet_iq_enable     (fet_iq_enable),
    .fet_inst          (fet_inst),
    .fet_inst_pc       (fet_inst_pc),
    .fet_pred_taken    (fet_pred_taken),
    .fet_is_c          (fet_is_c),
    .bp_update_enable  (bp_update_enable),
    .bp_update_pc      (bp_update_pc),
    .bp_update_taken   (bp_update_taken)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rdy, rst, flush, stall;
    logic [31:0] redir;
    logic        ready;
    logic [31:0] inst;
    logic        full, bpe;
    logic [31:0] bppc;
    logic        bpt;
    logic        chk_en, exp_en;
    logic [31:0] exp_pc;
    logic        exp_iq, chk_dat;
    logic [31:0] exp_inst, exp_ipc;
    logic        exp_tk, exp_c;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(
      input logic rdy_, input logic rst_, input logic fl, input logic st, input logic [31:0] rd,
      input logic rr, input logic [31:0] in, input logic fu, input logic be, input logic [31:0] bp,
      input logic bt, input logic ce, input logic ee, input logic [31:0] epc, input logic eiq,
      input logic cd, input logic [31:0] ei, input logic [31:0] eip, input logic et, input logic ec);
    vec_t v;
    v.rdy = rdy_; v.rst = rst_; v.flush = fl; v.stall = st; v.redir = rd;
    v.ready = rr; v.inst = in; v.full = fu; v.bpe = be; v.bppc = bp; v.bpt = bt;
    v.chk_en = ce; v.exp_en = ee; v.exp_pc = epc; v.exp_iq = eiq; v.chk_dat = cd;
    v.exp_inst = ei; v.exp_ipc = eip; v.exp_tk = et; v.exp_c = ec;
    return v;
  endfunction

  task automatic chk(input string name, input int row, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL row%0d %s: got %h want %h", row, name, got, exp);
    end
  endtask

  initial begin
    // rdy rst fl st redir ready inst full bpe bppc bpt | chk_en exp_en exp_pc exp_iq chk_dat inst ipc tk c
    vq.push_back(mk(1,1,0,0,0,     0,32'h0,0,0,0,0,      0,0,32'h0,  0,1,32'h0,32'h0,0,0));   // 0 reset
    vq.push_back(mk(1,0,0,0,0,     1,32'h13,0,0,0,0,     1,1,32'h4,  1,1,32'h13,32'h0,0,0));  // 1 addi
    vq.push_back(mk(1,0,0,0,0,     1,32'h1,0,0,0,0,      1,1,32'h6,  1,1,32'h1,32'h4,0,1));   // 2 c.nop
    vq.push_back(mk(1,0,0,0,0,     1,32'hA001,0,0,0,0,   1,1,32'h6,  1,1,32'hA001,32'h6,1,1));// 3 c.j 0
    vq.push_back(mk(1,0,1,0,32'h10,1,32'hA001,0,0,0,0,   1,0,32'h10, 0,0,0,0,0,0));           // 4 flush beats hit
    vq.push_back(mk(1,0,0,0,0,     1,32'h008000EF,0,0,0,0,1,1,32'h18,1,1,32'h008000EF,32'h10,1,0)); // 5 jal
    vq.push_back(mk(1,0,1,0,32'h20,0,32'h0,0,0,0,0,      1,0,32'h20, 0,0,0,0,0,0));           // 6
    vq.push_back(mk(1,0,0,0,0,     1,32'h863,0,0,0,0,    1,1,32'h24, 1,1,32'h863,32'h20,0,0));// 7 beq, BHT 01
    vq.push_back(mk(1,0,0,0,0,     0,32'h0,0,1,32'h20,1, 1,1,32'h24, 0,0,0,0,0,0));           // 8 miss + train
    vq.push_back(mk(1,0,1,0,32'h20,0,32'h0,0,1,32'h20,1, 1,0,32'h20, 0,0,0,0,0,0));           // 9 train + flush
    vq.push_back(mk(1,0,0,0,0,     1,32'h863,0,0,0,0,    1,1,32'h30, 1,1,32'h863,32'h20,1,0));// 10 beq taken
    vq.push_back(mk(1,0,1,0,32'h40,0,32'h0,0,0,0,0,      1,0,32'h40, 0,0,0,0,0,0));           // 11
    vq.push_back(mk(1,0,0,0,0,     1,32'h8067,0,0,0,0,   1,1,32'h44, 1,1,32'h8067,32'h40,0,0));// 12 ret
    vq.push_back(mk(1,0,0,0,0,     1,32'h13,0,0,0,0,     1,0,32'h44, 0,0,0,0,0,0));           // 13 WAIT holds
    vq.push_back(mk(1,0,1,0,32'h100,1,32'h13,0,0,0,0,    1,0,32'h100,0,0,0,0,0,0));           // 14 redirect
    vq.push_back(mk(1,0,0,0,0,     1,32'h13,0,0,0,0,     1,1,32'h104,1,1,32'h13,32'h100,0,0));// 15 running again
    vq.push_back(mk(1,0,0,0,0,     1,32'h13,1,0,0,0,     1,1,32'h104,0,0,0,0,0,0));           // 16 iq_full
    vq.push_back(mk(1,0,1,1,32'h200,1,32'h13,0,0,0,0,    1,0,32'h200,0,0,0,0,0,0));           // 17 stall+flush
    vq.push_back(mk(1,0,0,1,0,     1,32'h13,0,0,0,0,     1,0,32'h200,0,0,0,0,0,0));           // 18 stall
    vq.push_back(mk(0,1,0,0,0,     1,32'h13,0,0,0,0,     1,1,32'h200,0,0,0,0,0,0));           // 19 rdy=0 blocks rst
    vq.push_back(mk(1,0,0,0,0,     1,32'h13,0,0,0,0,     1,1,32'h204,1,1,32'h13,32'h200,0,0));// 20
    vq.push_back(mk(0,0,0,0,0,     1,32'h1,0,0,0,0,      1,1,32'h204,1,1,32'h13,32'h200,0,0));// 21 frozen pulse
    vq.push_back(mk(1,1,0,0,0,     1,32'h13,0,0,0,0,     1,1,32'h0,  0,1,32'h0,32'h0,0,0));   // 22 reset, BHT->01
    vq.push_back(mk(1,0,0,0,0,     0,32'h0,0,1,32'h20,1, 1,1,32'h0,  0,0,0,0,0,0));           // 23 ->10
    vq.push_back(mk(1,0,0,0,0,     0,32'h0,0,1,32'h20,1, 1,1,32'h0,  0,0,0,0,0,0));           // 24 ->11
    vq.push_back(mk(1,0,0,0,0,     0,32'h0,0,1,32'h20,1, 1,1,32'h0,  0,0,0,0,0,0));           // 25 sat 11
    vq.push_back(mk(1,0,0,0,0,     0,32'h0,0,1,32'h20,0, 1,1,32'h0,  0,0,0,0,0,0));           // 26 ->10
    vq.push_back(mk(1,0,1,0,32'h20,0,32'h0,0,1,32'h20,0, 1,0,32'h20, 0,0,0,0,0,0));           // 27 ->01
    vq.push_back(mk(1,0,0,0,0,     1,32'h863,0,0,0,0,    1,1,32'h24, 1,1,32'h863,32'h20,0,0));// 28 not taken
    vq.push_back(mk(1,0,0,0,0,     0,32'h0,0,1,32'h20,0, 1,1,32'h24, 0,0,0,0,0,0));           // 29 ->00
    vq.push_back(mk(1,0,0,0,0,     0,32'h0,0,1,32'h20,0, 1,1,32'h24, 0,0,0,0,0,0));           // 30 sat 00
    vq.push_back(mk(1,0,0,0,0,     0,32'h0,0,1,32'h20,0, 1,1,32'h24, 0,0,0,0,0,0));           // 31 sat 00
    vq.push_back(mk(1,0,1,0,32'h20,0,32'h0,0,1,32'h20,1, 1,0,32'h20, 0,0,0,0,0,0));           // 32 ->01
    vq.push_back(mk(1,0,0,0,0,     1,32'h863,0,0,0,0,    1,1,32'h24, 1,1,32'h863,32'h20,0,0));// 33 not taken
    vq.push_back(mk(1,0,1,0,32'h20,0,32'h0,0,0,0,0,      1,0,32'h20, 0,0,0,0,0,0));           // 34
    vq.push_back(mk(1,0,0,0,0,     1,32'h863,0,1,32'h20,1,1,1,32'h24, 1,1,32'h863,32'h20,0,0));// 35 same-edge old value
    vq.push_back(mk(1,0,0,0,0,     1,32'h8082,0,0,0,0,   1,1,32'h26, 1,1,32'h8082,32'h24,0,1));// 36 c.jr
    vq.push_back(mk(1,0,0,0,0,     1,32'h13,0,1,32'h78,1,1,0,32'h26, 0,0,0,0,0,0));           // 37 WAIT + train 0x78
    vq.push_back(mk(1,0,1,0,32'h80,0,32'h0,0,0,0,0,      1,0,32'h80, 0,0,0,0,0,0));           // 38
    vq.push_back(mk(1,0,0,0,0,     1,32'hFF9FF06F,0,0,0,0,1,1,32'h78,1,1,32'hFF9FF06F,32'h80,1,0)); // 39 jal -8
    vq.push_back(mk(1,0,0,0,0,     1,32'hFC75,0,0,0,0,   1,1,32'h74, 1,1,32'hFC75,32'h78,1,1));// 40 c.bnez -4 taken
    vq.push_back(mk(1,0,0,0,0,     0,32'h0,0,0,0,0,      1,1,32'h74, 0,0,0,0,0,0));           // 41 miss

    for (int i = 0; i < vq.size(); i++) begin
      rdy              = vq[i].rdy;
      rst              = vq[i].rst;
      flush            = vq[i].flush;
      stall            = vq[i].stall;
      rob_redirect_pc  = vq[i].redir;
      icache_ready     = vq[i].ready;
      icache_inst      = vq[i].inst;
      iq_full          = vq[i].full;
      bp_update_enable = vq[i].bpe;
      bp_update_pc     = vq[i].bppc;
      bp_update_taken  = vq[i].bpt;
      #1;
      if (vq[i].chk_en) chk("icache_en", i, {31'd0, fet_icache_enable}, {31'd0, vq[i].exp_en});
      @(posedge clk);
      #1;
      chk("fet_pc", i, fet_pc, vq[i].exp_pc);
      chk("iq_en", i, {31'd0, fet_iq_enable}, {31'd0, vq[i].exp_iq});
      if (vq[i].chk_dat) begin
        chk("inst", i, fet_inst, vq[i].exp_inst);
        chk("inst_pc", i, fet_inst_pc, vq[i].exp_ipc);
        chk("taken", i, {31'd0, fet_pred_taken}, {31'd0, vq[i].exp_tk});
        chk("is_c", i, {31'd0, fet_is_c}, {31'd0, vq[i].exp_c});
      end
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
